// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divider: state encoding, default width
// and the quotient value reported on a divide by zero.
package hilo_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Quotient returned for a zero divisor (all ones).
    localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and the difference fits a WIDTH+1 bit signed range.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // Non-negative difference: keep it and emit a 1; otherwise restore.
    assign o_qbit = ~w_diff[WIDTH];
    assign o_rem  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle DIV/DIVU unit feeding HI (remainder) and LO (quotient).
// Handshake: start is sampled only while IDLE (busy low); once accepted the
// operands may change. busy stays high until the block is back in IDLE, and
// done pulses for exactly one cycle with the results, which then hold until
// the next operation loads new ones.
module hilo_divider
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE     = 1;
    localparam logic [WIDTH-1:0] ZQ      = {WIDTH{DIV_ZERO_QUOT[0]}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_dsr;      // divisor magnitude
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;

    // Operand signs only matter in signed mode; magnitudes follow from them.
    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dsr_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + ONE) : dividend;
    assign w_dsr_mag = w_dsr_neg ? (~divisor + ONE) : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dsr),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // Control FSM and datapath registers; outputs are registered alongside state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rem         <= '0;
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_cnt         <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (divisor == '0) begin
                            // Zero divisor skips the iterations entirely.
                            r_quotient    <= ZQ;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_dvd   <= w_dvd_mag;
                            r_dsr   <= w_dsr_mag;
                            r_q_neg <= w_dvd_neg ^ w_dsr_neg;
                            r_r_neg <= w_dvd_neg;
                            r_cnt   <= CNT_MAX;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Truncating division: quotient sign from both operands,
                    // remainder sign from the dividend. -2^(W-1)/-1 wraps.
                    r_quotient    <= r_q_neg ? (~r_dvd + ONE) : r_dvd;
                    r_remainder   <= r_r_neg ? (~r_rem + ONE) : r_rem;
                    r_div_by_zero <= 1'b0;
                    r_done        <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed bench for hilo_divider: hand-computed DIV/DIVU vectors, divide by
// zero, ignored starts, back-to-back spacing and reset abort.
module tb_hilo_divider;
  import hilo_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  state_t      dbg_state;

  int n_cmp;
  int n_fail;

  hilo_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) until done is seen; lat counts edges from the current point.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k <= 60; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one request so that the next edge (E0) accepts it, then scrambles
  // the operand inputs and waits for done. Returns sampled just after E0 (busy0)
  // and edges from E0 to the first done sample.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy0);
    @(posedge clk);
    #1;
    start = 1'b1;
    is_signed = s;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    busy0 = busy;
    wait_done(lat);
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quot: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_rem: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  // 100 / 7 unsigned: busy from E0, done only after E33, low again after E34.
  task automatic test_unsigned_basic();
    int   lat;
    logic b0;
    issue(1'b0, 32'd100, 32'd7, lat, b0);
    n_cmp++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_e0: got %b want 1", b0); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
    n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_quot: got %h want %h", quotient, 32'd14); end
    n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_rem: got %h want %h", remainder, 32'd2); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", div_by_zero); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_e33: got %b want 1", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_e34: got %b want 0", busy); end
    n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_quot_hold: got %h want %h", quotient, 32'd14); end
  endtask

  // Signed truncation with each sign combination.
  task automatic test_signed();
    int   lat;
    logic b0;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, lat, b0);  // -7 / 2 = -3 r -1
    n_cmp++; if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sgn_m7_2_quot: got %h want FFFFFFFD", quotient); end
    n_cmp++; if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sgn_m7_2_rem: got %h want FFFFFFFF", remainder); end
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, lat, b0);  // 7 / -2 = -3 r 1
    n_cmp++; if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sgn_7_m2_quot: got %h want FFFFFFFD", quotient); end
    n_cmp++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL sgn_7_m2_rem: got %h want 1", remainder); end
    issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, b0);  // -7 / -2 = 3 r -1
    n_cmp++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL sgn_m7_m2_quot: got %h want 3", quotient); end
    n_cmp++; if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sgn_m7_m2_rem: got %h want FFFFFFFF", remainder); end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL sgn_latency: got %0d want 33", lat); end
  endtask

  // Same bit patterns treated as unsigned.
  task automatic test_unsigned_same();
    int   lat;
    logic b0;
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, lat, b0);
    n_cmp++; if (quotient !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL uns_quot: got %h want 7FFFFFFC", quotient); end
    n_cmp++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL uns_rem: got %h want 1", remainder); end
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b0);
    n_cmp++; if (quotient !== 32'd1) begin n_fail++; $display("FAIL uns_max_quot: got %h want 1", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL uns_max_rem: got %h want 0", remainder); end
  endtask

  // Most-negative dividend over all-ones divisor in both modes.
  task automatic test_overflow();
    int   lat;
    logic b0;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0);
    n_cmp++; if (quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_s_quot: got %h want 80000000", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL ovf_s_rem: got %h want 0", remainder); end
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0);
    n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL ovf_u_quot: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_u_rem: got %h want 80000000", remainder); end
  endtask

  // 5 / 0: results and done immediately after E0, idle after E1.
  task automatic test_div_zero();
    int   lat;
    logic b0;
    issue(1'b1, 32'd5, 32'd0, lat, b0);
    n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL dz_latency: got %0d want 0", lat); end
    n_cmp++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL dz_busy_e0: got %b want 1", b0); end
    n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot: got %h want FFFFFFFF", quotient); end
    n_cmp++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL dz_rem: got %h want 5", remainder); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy_e1: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL dz_done_e1: got %b want 0", done); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_hold: got %b want 1", div_by_zero); end
  endtask

  // A second start while busy must not disturb or queue behind the first.
  task automatic test_ignore_start();
    int lat;
    int pulses;
    @(posedge clk);
    #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end  // after E4
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);  // E5
    #1;
    start = 1'b0;
    wait_done(lat);
    n_cmp++; if (lat !== 28) begin n_fail++; $display("FAIL ign_latency: got %0d want 28", lat); end
    n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL ign_quot: got %h want %h", quotient, 32'd14); end
    n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL ign_rem: got %h want 2", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ign_dz_clear: got %b want 0", div_by_zero); end
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL ign_extra_done: got %0d want 0", pulses); end
  endtask

  // start held through DONE is only taken once IDLE: 35-cycle spacing.
  task automatic test_back_to_back();
    int   lat;
    logic b0;
    issue(1'b0, 32'd9, 32'd3, lat, b0);  // positioned just after E33
    n_cmp++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL b2b_a_quot: got %h want 3", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_a_rem: got %h want 0", remainder); end
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);  // E34: in DONE, start ignored
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_reject: got %b want 0", busy); end
    @(posedge clk);  // E35: accepted
    #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", busy); end
    wait_done(lat);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL b2b_b_quot: got %h want %h", quotient, 32'd14); end
    n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL b2b_b_rem: got %h want 2", remainder); end
  endtask

  // Reset mid-operation clears everything, no done, then a fresh op works.
  task automatic test_reset_abort();
    int   lat;
    int   pulses;
    logic b0;
    @(posedge clk);
    #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);  // E5
    #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_mid: got %b want 1", busy); end
    repeat (4) begin @(posedge clk); #1; end  // after E9
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL rst_quot: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL rst_rem: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dz: got %b want 0", div_by_zero); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d want 0", pulses); end
    issue(1'b0, 32'd100, 32'd7, lat, b0);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 33", lat); end
    n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL rst_after_quot: got %h want %h", quotient, 32'd14); end
    n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL rst_after_rem: got %h want 2", remainder); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_unsigned_basic();
    test_signed();
    test_unsigned_same();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
